// File: rtl/latch_demux2_8bit.sv
// Write-side demux: latches TI bus data into one of four holding registers on a
// synchronised write strobe, with per-register update flags cleared by a Pi-side ack.
module latch_demux2_8bit #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_n,
    input  logic             a_addr,
    input  logic             b_addr,
    input  logic             c_addr,
    input  logic             d_addr,
    input  logic [WIDTH-1:0] din,
    input  logic [3:0]       ack,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [3:0]       upd,
    output logic             err
);

    // state  | meaning
    // IDLE   | waiting for a falling write strobe
    // CAPT   | address/data captured, waiting for strobe release
    // COMMIT | single cycle that applies the captured write
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CAPT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_we_s_q;
    state_t                 r_state;
    logic [3:0]             r_sel;
    logic [WIDTH-1:0]       r_dat;
    logic [WIDTH-1:0]       r_hold [4];
    logic [3:0]             r_upd;
    logic                   r_err;

    logic       w_we_s;
    logic       w_fall;
    logic       w_rise;
    logic       w_sel_any;
    logic       w_sel_multi;
    logic       w_sel_onehot;
    logic [3:0] w_set;

    assign w_we_s = r_sync[SYNC_STAGES-1];
    assign w_fall = r_we_s_q & ~w_we_s;
    assign w_rise = ~r_we_s_q & w_we_s;

    assign w_sel_any    = |r_sel;
    assign w_sel_multi  = |(r_sel & (r_sel - 4'd1));
    assign w_sel_onehot = w_sel_any & ~w_sel_multi;
    assign w_set        = (r_state == ST_COMMIT && w_sel_onehot) ? r_sel : 4'b0000;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync   <= '1;
            r_we_s_q <= 1'b1;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], we_n};
            r_we_s_q <= w_we_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_sel   <= 4'b0000;
            r_dat   <= '0;
            r_upd   <= 4'b0000;
            r_err   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            r_err <= 1'b0;
            // A commit setting a flag wins over an ack clearing it in the same cycle
            r_upd <= (r_upd & ~ack) | w_set;
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_sel   <= {d_addr, c_addr, b_addr, a_addr};
                        r_dat   <= din;
                        r_state <= ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    if (w_rise) begin
                        r_state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    for (int i = 0; i < 4; i++) begin
                        if (w_set[i]) begin
                            r_hold[i] <= r_dat;
                        end
                    end
                    r_err   <= w_sel_multi;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign a   = r_hold[0];
    assign b   = r_hold[1];
    assign c   = r_hold[2];
    assign d   = r_hold[3];
    assign upd = r_upd;
    assign err = r_err;

endmodule

// File: tb/tb_latch_demux2_8bit.sv
// Directed bench for latch_demux2_8bit: latency, flag set/ack rules, select errors, reset abort.
module tb_latch_demux2_8bit;

    logic       clk;
    logic       reset;
    logic       we_n;
    logic       a_addr, b_addr, c_addr, d_addr;
    logic [7:0] din;
    logic [3:0] ack;
    logic [7:0] a, b, c, d;
    logic [3:0] upd;
    logic       err;

    int n_cmp;
    int n_bad;

    latch_demux2_8bit #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .we_n(we_n),
        .a_addr(a_addr), .b_addr(b_addr), .c_addr(c_addr), .d_addr(d_addr),
        .din(din), .ack(ack),
        .a(a), .b(b), .c(c), .d(d), .upd(upd), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // sel is {d,c,b,a}; strobe low 4 cycles, then released; caller waits for commit
    task automatic strobe(input logic [3:0] sel, input logic [7:0] data);
        {d_addr, c_addr, b_addr, a_addr} = sel;
        din  = data;
        we_n = 1'b0;
        tick(4);
        we_n = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        we_n = 1'b1; {d_addr, c_addr, b_addr, a_addr} = 4'b0000; din = 8'h00; ack = 4'b0000;
        tick(3);
        reset = 1'b0;
        tick(1);
        n_cmp++;
        if ({a, b, c, d} !== 32'h0) begin
            n_bad++; $display("FAIL reset_regs got %h want 00000000", {a, b, c, d});
        end
        n_cmp++;
        if (upd !== 4'b0000) begin
            n_bad++; $display("FAIL reset_upd got %b want 0000", upd);
        end
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++; $display("FAIL reset_err got %b want 0", err);
        end
    endtask

    task automatic test_write_a;
        strobe(4'b0001, 8'haa);
        tick(3);
        n_cmp++;
        if (a !== 8'h00) begin
            n_bad++; $display("FAIL latency_early a got %h want 00", a);
        end
        tick(1);
        n_cmp++;
        if (a !== 8'haa) begin
            n_bad++; $display("FAIL write_a got %h want aa", a);
        end
        n_cmp++;
        if (upd !== 4'b0001) begin
            n_bad++; $display("FAIL write_a_upd got %b want 0001", upd);
        end
        n_cmp++;
        if ({b, c, d} !== 24'h0) begin
            n_bad++; $display("FAIL write_a_others got %h want 000000", {b, c, d});
        end
        ack = 4'b0001;
        tick(1);
        ack = 4'b0000;
        n_cmp++;
        if (upd !== 4'b0000) begin
            n_bad++; $display("FAIL ack_a got %b want 0000", upd);
        end
    endtask

    task automatic test_write_bcd;
        strobe(4'b0010, 8'hbb); tick(4);
        strobe(4'b0100, 8'hcc); tick(4);
        strobe(4'b1000, 8'hdd); tick(4);
        n_cmp++;
        if ({a, b, c, d} !== 32'haabbccdd) begin
            n_bad++; $display("FAIL write_bcd got %h want aabbccdd", {a, b, c, d});
        end
        n_cmp++;
        if (upd !== 4'b1110) begin
            n_bad++; $display("FAIL write_bcd_upd got %b want 1110", upd);
        end
    endtask

    task automatic test_bad_select;
        int err_seen;
        err_seen = 0;
        {d_addr, c_addr, b_addr, a_addr} = 4'b0000;
        din = 8'h55; we_n = 1'b0;
        for (int i = 0; i < 4; i++) begin tick(1); if (err !== 1'b0) err_seen++; end
        we_n = 1'b1;
        for (int i = 0; i < 6; i++) begin tick(1); if (err !== 1'b0) err_seen++; end
        n_cmp++;
        if (err_seen != 0) begin
            n_bad++; $display("FAIL nosel_err got %0d high cycles want 0", err_seen);
        end
        n_cmp++;
        if ({a, b, c, d, upd} !== {32'haabbccdd, 4'b1110}) begin
            n_bad++; $display("FAIL nosel_state got %h/%b want aabbccdd/1110", {a, b, c, d}, upd);
        end
        strobe(4'b0011, 8'hee);
        tick(3);
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++; $display("FAIL multi_err_early got %b want 0", err);
        end
        tick(1);
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++; $display("FAIL multi_err_pulse got %b want 1", err);
        end
        tick(1);
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++; $display("FAIL multi_err_width got %b want 0", err);
        end
        n_cmp++;
        if ({a, b, upd} !== {16'haabb, 4'b1110}) begin
            n_bad++; $display("FAIL multi_state got %h/%b want aabb/1110", {a, b}, upd);
        end
    endtask

    task automatic test_ack_collision;
        ack = 4'b0001;
        strobe(4'b0001, 8'h11);
        tick(4);
        ack = 4'b0000;
        n_cmp++;
        if (upd !== 4'b1111 || a !== 8'h11) begin
            n_bad++; $display("FAIL set_beats_ack got %b/%h want 1111/11", upd, a);
        end
        strobe(4'b0001, 8'h22);
        tick(4);
        n_cmp++;
        if (upd !== 4'b1111 || a !== 8'h22) begin
            n_bad++; $display("FAIL overwrite got %b/%h want 1111/22", upd, a);
        end
        ack = 4'b1111;
        tick(1);
        ack = 4'b0000;
        n_cmp++;
        if (upd !== 4'b0000) begin
            n_bad++; $display("FAIL ack_all got %b want 0000", upd);
        end
    endtask

    task automatic test_reset_abort;
        a_addr = 1'b1; b_addr = 1'b0; c_addr = 1'b0; d_addr = 1'b0;
        din = 8'h77; we_n = 1'b0;
        tick(4);
        reset = 1'b1;
        tick(3);
        we_n = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(10);
        n_cmp++;
        if ({a, b, c, d} !== 32'h0) begin
            n_bad++; $display("FAIL abort_regs got %h want 00000000", {a, b, c, d});
        end
        n_cmp++;
        if (upd !== 4'b0000 || err !== 1'b0) begin
            n_bad++; $display("FAIL abort_flags got %b/%b want 0000/0", upd, err);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset;
        test_write_a;
        test_write_bcd;
        test_bad_select;
        test_ack_collision;
        test_reset_abort;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
